// File: rtl/ap_tag_unit_if.sv
// ap_tag_unit_if: command handshake and scan-result bus between the AP controller and the tag unit
interface ap_tag_unit_if #(parameter int IW = 10);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic          res_valid;
  logic [IW-1:0] res_count;
  logic [IW-1:0] res_first;
  logic          res_none;
  modport master(output cmd_valid, cmd_op, input cmd_ready, res_valid, res_count, res_first, res_none);
  modport slave(input cmd_valid, cmd_op, output cmd_ready, res_valid, res_count, res_first, res_none);
endinterface

// File: rtl/ap_tag_unit.sv
// ap_tag_unit: tag register behind the CAM with logical ops and a chunked match scan.
// Define AP_TAG_COUNT_EN to build the match-count accumulator; otherwise res_count is 0.
module ap_tag_unit #(
  parameter int CELL_QUANT = 512,
  parameter int SCAN_WIDTH = 32,
  localparam int IW = $clog2(CELL_QUANT) + 1
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst_n,
  input  logic [CELL_QUANT-1:0] tags,
  input  logic                  ap_write,
  output logic [CELL_QUANT-1:0] cell_wea_ctrl_ap,
  output logic [CELL_QUANT-1:0] tag_q,
  ap_tag_unit_if.slave          bus
);
  localparam int N  = CELL_QUANT / SCAN_WIDTH;
  localparam int KW = $clog2(N);
  localparam int OW = $clog2(SCAN_WIDTH);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t                state;
  logic                  ready, found, keep, res_valid, res_none;
  logic [KW-1:0]         k;
  logic [IW-1:0]         first, res_first;
  logic [SCAN_WIDTH-1:0] chunk;
  logic [OW-1:0]         low;
  assign chunk = tag_q[int'(k)*SCAN_WIDTH +: SCAN_WIDTH];
  always_comb begin
    low = '0;
    for (int i = SCAN_WIDTH - 1; i >= 0; i--) if (chunk[i]) low = OW'(i);
  end
  always_ff @(posedge CLK100MHZ or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      k         <= '0;
      found     <= 1'b0;
      first     <= '0;
      keep      <= 1'b0;
      tag_q     <= '0;
      res_valid <= 1'b0;
      res_first <= '0;
      res_none  <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          k     <= '0;
          found <= 1'b0;
          first <= '0;
          keep  <= bus.cmd_op == 3'd6;
          case (bus.cmd_op)
            3'd1: tag_q <= tags;
            3'd2: tag_q <= tag_q & tags;
            3'd3: tag_q <= tag_q | tags;
            3'd4: tag_q <= '0;
            3'd5: tag_q <= '1;
            3'd6, 3'd7: begin
              state <= SCAN;
              ready <= 1'b0;
            end
            default: ;
          endcase
        end
        SCAN: begin
          k <= k + 1'b1;
          if (!found && |chunk) begin
            found <= 1'b1;
            first <= IW'({k, low});
          end
          if (k == KW'(N - 1)) begin
            state     <= DONE;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          ready     <= 1'b1;
          res_first <= first;
          res_none  <= !found;
          if (keep) tag_q <= found ? CELL_QUANT'(1) << first : '0;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef AP_TAG_COUNT_EN
  logic [IW-1:0] pop, acc, res_count;
  always_comb begin
    pop = '0;
    for (int i = 0; i < SCAN_WIDTH; i++) pop = pop + IW'(chunk[i]);
  end
  always_ff @(posedge CLK100MHZ or negedge rst_n)
    if (!rst_n) begin
      acc       <= '0;
      res_count <= '0;
    end else if (state == IDLE) acc <= '0;
    else if (state == SCAN) acc <= acc + pop;
    else res_count <= acc;
  assign bus.res_count = res_count;
`else
  assign bus.res_count = '0;
`endif
  assign bus.cmd_ready     = ready;
  assign bus.res_valid     = res_valid;
  assign bus.res_first     = res_first;
  assign bus.res_none      = res_none;
  assign cell_wea_ctrl_ap  = ap_write ? tag_q : '0;
endmodule

// File: doc/ap_tag_unit.md
# ap_tag_unit

Tag-register stage directly downstream of the CAM array in the associative-processor datapath. It captures the CAM's per-cell match vector (`tags`) and combines successive matches with logical ops. It drives the CAM's parallel-write enable vector (`cell_wea_ctrl_ap`) from the held tags. A multi-cycle scan engine reports match count and lowest matching index back to the AP controller.

## Interface

Parameters:
- `CELL_QUANT`, 512, number of CAM cells. Must be a power of two.
- `SCAN_WIDTH`, 32, tag bits examined per scan cycle. Must be a power of two that divides `CELL_QUANT`.
- Derived: `IW` = clogb2(`CELL_QUANT`) (floor(log2)+1, i.e. 10 for 512); `N` = `CELL_QUANT`/`SCAN_WIDTH`.

Ports:
- `CLK100MHZ` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tags` in `CELL_QUANT`: match vector from the CAM.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 3: opcode, sampled when `cmd_valid & cmd_ready`.
- `ap_write` in 1: gates the held tags onto the CAM write enables.
- `cell_wea_ctrl_ap` out `CELL_QUANT`: `ap_write ? tag_q : 0`. Combinational from the register.
- `tag_q` out `CELL_QUANT`: current tag register.
- `res_valid` out 1: one-cycle pulse when scan results update.
- `res_count` out `IW`: number of set bits in the scanned vector.
- `res_first` out `IW`: lowest set index, or 0 if none.
- `res_none` out 1: scanned vector was all zero.

## Operation

- Handshake: a command is accepted on a rising edge with `cmd_valid & cmd_ready`. `cmd_ready` = (state == IDLE).

Opcodes:
- 0 NOP: no effect.
- 1 LOAD: `tag_q <= tags`.
- 2 AND: `tag_q <= tag_q & tags`.
- 3 OR: `tag_q <= tag_q | tags`.
- 4 CLEAR: `tag_q <= 0`.
- 5 SET_ALL: `tag_q <= all ones`.
- 6 KEEP_FIRST: scan, then clear all bits of `tag_q` except the lowest set bit.
- 7 SCAN: scan only; `tag_q` is unchanged.
- Ops 0–5 complete at the accept edge. The state stays IDLE.

FSM states:
- IDLE: op 6 or 7 accepted → SCAN, with chunk index k=0, count accumulator 0, found flag 0.
- SCAN: each cycle, examine `tag_q[k*SCAN_WIDTH +: SCAN_WIDTH]`.
  - Add its popcount to the accumulator.
  - If not yet found and the chunk is non-zero, record k*SCAN_WIDTH + lowest set offset and set found.
  - k increments. After chunk N-1 → DONE.
- DONE: one cycle.
  - `res_valid`=1; `res_*` registers load the accumulated values.
  - For KEEP_FIRST, `tag_q` becomes one-hot at `res_first`, or stays 0 if none.
  - → IDLE.

Rules during scan:
- The `tags` input is ignored during SCAN/DONE.
- `tag_q` is stable because no commands are accepted.
- `ap_write` is honoured in every state.

Result outputs:
- `res_*` hold their value until the next DONE.
- Count arithmetic is unsigned `IW` bits; all-match yields exactly `CELL_QUANT`, which fits without overflow.

## Timing

- Single-cycle ops: `tag_q` is valid the cycle after the accept edge.
- Scan op accepted at edge t: SCAN occupies edges t+1..t+N, DONE is the cycle after edge t+N, and `cmd_ready` returns high after edge t+N+1.
  - `res_valid` is high during the DONE cycle, i.e. N+1 cycles after the accept edge.
  - `res_*` and the KEEP_FIRST `tag_q` update are visible from the cycle after DONE.
- Reset values: `tag_q`=0, `cell_wea_ctrl_ap`=0, state IDLE, `cmd_ready`=1 once out of reset, `res_valid`=0, `res_count`=0, `res_first`=0, `res_none`=0.
- Reset asserted mid-scan: immediate return to IDLE, with all registers set to their reset values. No `res_valid` pulse.
- No match: `res_none`=1, `res_count`=0, `res_first`=0.

## Configuration

- `AP_TAG_COUNT_EN` defined:
  - The popcount accumulator is built.
  - `res_count` reports the match count as described.
- Not defined:
  - The accumulator and popcount logic are omitted; `res_count` is constant 0.
  - The scan still runs N cycles and produces `res_first`/`res_none` with identical timing.

## Test plan

- Reset with `rst_n`=0 during scan: `tag_q`=0, `res_valid` never pulses, `cmd_ready`=1 after release.
- LOAD `tags`=0x...F0F0, then AND `tags`=0x...FF00: `tag_q`=0x...F000. With `ap_write`=1, `cell_wea_ctrl_ap`=`tag_q`; with `ap_write`=0, it is 0.
- SCAN with bits {37, 100, 511} set (512/32 config): `res_valid` N+1=17 cycles after accept, `res_count`=3, `res_first`=37, `res_none`=0, `cmd_ready` low throughout.
- KEEP_FIRST after SET_ALL: `res_count`=512, `res_first`=0, `tag_q`=1 afterwards.
- SCAN after CLEAR: `res_none`=1, `res_count`=0, `res_first`=0. KEEP_FIRST then leaves `tag_q`=0.
- Without `AP_TAG_COUNT_EN`: same vectors give `res_count`=0 with identical `res_first` and latency.
